instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: byte address fetched first after reset.
REQ-002 Parameter MEM_WORDS, default 32: number of instruction-memory words; word index >= MEM_WORDS is out of range.
REQ-003 Parameter HALT_INSTR, default 32'hFFFF_FFFF: encoding that stops fetch.
REQ-004 clk  in  1  sole clock, all state updates on rising edge.
REQ-005 rst  in  1  reset; synchronous and active-high, sampled on rising edge of clk.
REQ-006 imem_pc  out  32  byte address to instruction memory; always word aligned.
REQ-007 imem_instr  in  32  instruction word returned combinationally for imem_pc in the same cycle.
REQ-008 branch_valid  in  1  redirect request from execute.
REQ-009 branch_target  in  32  redirect byte address, qualified by branch_valid.
REQ-010 out_valid  out  1  head buffer entry valid toward decode.
REQ-011 out_instr  out  32  instruction of head entry.
REQ-012 out_pc  out  32  byte address of head entry.
REQ-013 out_ready  in  1  decode accepts head entry when out_valid && out_ready.
REQ-014 halted  out  1  fetch stopped on HALT_INSTR and buffer empty.
REQ-015 fault  out  1  fetch stopped on out-of-range address.

Function
REQ-016 imem_pc SHALL equal the internal pc register combinationally; pc[1:0] SHALL always be 2'b00.
REQ-017 Buffer SHALL be a 2-entry FIFO of {pc, instr}; out_valid = (count != 0); out_instr/out_pc = head entry, stable while out_valid && !out_ready.
REQ-018 Pop SHALL occur when out_valid && out_ready; push SHALL occur in state FETCH when count < 2, or count == 2 with a pop in the same cycle, and the current pc is in range.
REQ-019 On push, entry = {pc, imem_instr} and pc <= pc + 4 (32-bit wrap).
REQ-020 Latency: instruction at pc is visible on out_* the cycle after push (out_valid rises one cycle after reset release).
REQ-021 Throughput: with out_ready held high, one instruction SHALL be delivered per cycle with no bubbles.
REQ-022 States: FETCH, DRAIN, HALTED, FAULT.
REQ-023 FETCH -> DRAIN when pushed imem_instr == HALT_INSTR; the halt word itself is pushed and delivered; pc is not incremented.
REQ-024 FETCH -> FAULT when (pc >> 2) >= MEM_WORDS; no push occurs; fault asserts next cycle; existing entries still drain.
REQ-025 DRAIN: no push; DRAIN -> HALTED when count becomes 0; halted asserts in HALTED only.
REQ-026 HALTED and FAULT SHALL hold until redirect or reset; no fetch in either.
REQ-027 branch_valid SHALL have priority over push and pop in the same cycle: buffer flushed (count <= 0), pc <= {branch_target[31:2], 2'b00}, state <= FETCH, halted and fault cleared; no pop is counted that cycle.
REQ-028 Redirect in any state (including DRAIN, HALTED, FAULT) SHALL resume fetch; out_valid is 0 the cycle after redirect, target instruction valid the cycle after that.
REQ-029 Simultaneous push and pop with count == 2 SHALL keep count at 2; with count == 1 SHALL keep count at 1 with new head = old tail-next.
REQ-030 Reads of imem_instr SHALL be ignored in cycles with no push.

Reset
REQ-031 While rst is high at a clock edge: pc <= RESET_PC, count <= 0, state <= FETCH; out_valid = 0, halted = 0, fault = 0 the following cycle.
REQ-032 Reset SHALL override branch_valid, push and pop in the same cycle, including mid-drain or mid-redirect.
REQ-033 out_instr/out_pc SHALL be don't-care while out_valid = 0.

Verification
REQ-034 Reset, out_ready=1, memory words 0..3 = A,B,C,D -> out_pc 0,4,8,12 on consecutive cycles starting cycle 1 after reset release, out_instr A,B,C,D.
REQ-035 out_ready=0 for 5 cycles after reset -> count saturates at 2, imem_pc holds 8, out_pc stays 0; out_ready=1 -> 0,4,8 delivered back to back.
REQ-036 branch_valid=1, branch_target=32'h0000_0013 while count=2 -> next cycle out_valid=0, imem_pc=0x10; following cycle out_pc=0x10.
REQ-037 Word 3 = 32'hFFFF_FFFF -> words 0..3 delivered, pc holds 12, halted=1 the cycle after the halt word is popped; no further out_valid.
REQ-038 MEM_WORDS=4, no halt word -> after out_pc 12 delivered, fault=1, out_valid=0; branch to 0 -> fault=0, out_pc 0 delivered.
REQ-039 rst asserted during DRAIN with count=2 -> next cycle out_valid=0, halted=0, imem_pc=RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: walks pc through instruction memory, buffers up to two
// {pc, instr} entries toward decode, and stops on a halt word or an out-of-range pc.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned MEM_WORDS  = 32,
    parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    localparam logic [31:0] MEM_WORDS_W   = 32'(MEM_WORDS);
    localparam logic [31:0] RESET_PC_WORD = RESET_PC & 32'hFFFF_FFFC;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [1:0]  count_r;
    logic [31:0] head_pc_r;
    logic [31:0] head_instr_r;
    logic [31:0] tail_pc_r;
    logic [31:0] tail_instr_r;
    logic        halted_r;
    logic        fault_r;

    logic        pop_s;
    logic        push_s;
    logic        in_range_s;
    logic        halt_hit_s;
    logic [1:0]  count_next_s;
    logic [31:0] branch_pc_s;

    // Handshake decode: pop/push qualification and next occupancy.
    always_comb begin
        pop_s        = 1'b0;
        push_s       = 1'b0;
        halt_hit_s   = 1'b0;
        count_next_s = count_r;
        branch_pc_s  = branch_target & 32'hFFFF_FFFC;
        in_range_s   = ({2'b00, pc_r[31:2]} < MEM_WORDS_W);

        if (count_r != 2'd0) begin
            pop_s = out_ready;
        end else begin
            pop_s = 1'b0;
        end

        // A full buffer still accepts a push when the head leaves this cycle.
        if ((state_r == ST_FETCH) && in_range_s && ((count_r != 2'd2) || pop_s)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end

        if (push_s && (imem_instr == HALT_INSTR)) begin
            halt_hit_s = 1'b1;
        end else begin
            halt_hit_s = 1'b0;
        end

        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + 2'd1;
            2'b01:   count_next_s = count_r - 2'd1;
            default: count_next_s = count_r;
        endcase
    end

    // Fetch state machine, pc, and the two-entry buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_FETCH;
            pc_r         <= RESET_PC_WORD;
            count_r      <= 2'd0;
            head_pc_r    <= 32'h0000_0000;
            head_instr_r <= 32'h0000_0000;
            tail_pc_r    <= 32'h0000_0000;
            tail_instr_r <= 32'h0000_0000;
            halted_r     <= 1'b0;
            fault_r      <= 1'b0;
        end else if (branch_valid) begin
            state_r  <= ST_FETCH;
            pc_r     <= branch_pc_s;
            count_r  <= 2'd0;
            halted_r <= 1'b0;
            fault_r  <= 1'b0;
        end else begin
            if (pop_s) begin
                if (push_s && (count_r == 2'd1)) begin
                    head_pc_r    <= pc_r;
                    head_instr_r <= imem_instr;
                end else begin
                    head_pc_r    <= tail_pc_r;
                    head_instr_r <= tail_instr_r;
                    if (push_s) begin
                        tail_pc_r    <= pc_r;
                        tail_instr_r <= imem_instr;
                    end
                end
            end else if (push_s) begin
                if (count_r == 2'd0) begin
                    head_pc_r    <= pc_r;
                    head_instr_r <= imem_instr;
                end else begin
                    tail_pc_r    <= pc_r;
                    tail_instr_r <= imem_instr;
                end
            end

            count_r <= count_next_s;

            // The pc parks on the halt word so a later redirect is the only way on.
            if (push_s && !halt_hit_s) begin
                pc_r <= pc_r + 32'd4;
            end

            case (state_r)
                ST_FETCH: begin
                    if (!in_range_s) begin
                        state_r <= ST_FAULT;
                        fault_r <= 1'b1;
                    end else if (halt_hit_s) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (count_next_s == 2'd0) begin
                        state_r  <= ST_HALTED;
                        halted_r <= 1'b1;
                    end
                end
                ST_HALTED: state_r <= ST_HALTED;
                ST_FAULT:  state_r <= ST_FAULT;
                default: begin
                    state_r  <= ST_FETCH;
                    halted_r <= 1'b0;
                    fault_r  <= 1'b0;
                end
            endcase
        end
    end

    assign imem_pc   = pc_r;
    assign out_valid = (count_r != 2'd0);
    assign out_pc    = head_pc_r;
    assign out_instr = head_instr_r;
    assign halted    = halted_r;
    assign fault     = fault_r;

endmodule
